// File: rtl/booth_r16_seq_ctrl.sv
// Iterative radix-16 Booth sequencer: walks B one 4-bit group per clock through
// a single combinational encoder and accumulates the weighted partial products.
module booth_r16_seq_ctrl #(
    parameter int LENGTH         = 32,
    parameter bit UNSIGNED_BOOTH = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LENGTH-1:0]     a_i,
    input  logic [LENGTH-1:0]     b_i,
    output logic [LENGTH-1:0]     pp_a_o,
    output logic [4:0]            pp_sel_o,
    input  logic [LENGTH+3:0]     pp_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2*LENGTH-1:0]   prod_o,
    output logic                  busy_o
);

    localparam int N_GRP = LENGTH / 4 + int'(UNSIGNED_BOOTH);
    localparam int BX_W  = 4 * N_GRP;
    localparam int ACC_W = 2 * LENGTH + 4;
    localparam int CNT_W = $clog2(N_GRP + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [BX_W:0]       sreg_q;   // {bx, bx[-1]}; bits [4:0] are the live window
    logic [LENGTH-1:0]   a_q;

    logic [BX_W-1:0]     bx_load;
    logic [ACC_W-1:0]    pp_shift;
    logic                last_grp;

    // Extra top group in unsigned mode sees only zero-extension bits, so the
    // final digit absorbs B's MSB as a positive weight.
    always_comb begin
        if (UNSIGNED_BOOTH) bx_load = BX_W'(b_i);
        else                bx_load = BX_W'($signed(b_i));
    end

    assign pp_shift = ACC_W'($signed(pp_i)) << {cnt_q, 2'b00};
    assign last_grp = (cnt_q == CNT_W'(N_GRP - 1));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)  state_d = RUN;
            RUN:     if (last_grp)    state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sreg_q  <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q    <= a_i;
                        sreg_q <= {bx_load, 1'b0};
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    acc_q  <= acc_q + pp_shift;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Shifting by 4 leaves the old window top bit as the new w0.
                    sreg_q <= sreg_q >> 4;
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN) || (state_q == DONE);
    assign pp_sel_o    = (state_q == RUN) ? sreg_q[4:0] : 5'b00000;
    assign pp_a_o      = a_q;
    assign prod_o      = acc_q[2*LENGTH-1:0];

endmodule
